// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// holds one registered instruction in the issue slot until it retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        PCsrc,
    input  logic        JUMPRT,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        fault_q, fault_d;
    logic [31:0] nextPc;
    logic        misaligned;
    logic        fetchDone;

    // jalr clears bit 0 of the register-relative target before alignment is judged
    always_comb begin
        nextPc = pc_q + 32'd4;
        if (PCsrc) begin
            nextPc = JUMPRT ? (ALUResult & 32'hFFFF_FFFE) : (pc_q + ImmExt);
        end
    end

    assign misaligned = |nextPc[1:0];
    assign fetchDone  = imem_req & imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: if (fetchDone) state_d = ISSUE;
            ISSUE: if (!stall) state_d = misaligned ? HALT : FETCH;
            default: state_d = HALT;
        endcase
    end

    // Request is gated by reset so it drops the moment reset is raised mid-fetch
    always_comb begin
        imem_req    = (state_q == FETCH) && !rst;
        instr_valid = (state_q == ISSUE);
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        fault_d   = fault_q;
        unique case (state_q)
            FETCH: begin
                if (fetchDone) instr_d = imem_rdata;
            end
            ISSUE: begin
                if (!stall) begin
                    instr_d = NOP;
                    if (misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        pc_d      = nextPc;
                        instret_d = instret_q + 32'd1;
                    end
                end
            end
            default: begin
                instr_d = NOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            instret_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign fetch_fault = fault_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with adjustable ack delay, a
// transaction-level reference model, and directed branch/stall/reset scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int PH_FETCHING = 0;
    localparam int PH_ISSUING  = 1;
    localparam int PH_HALTED   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        PCsrc = 1'b0;
    logic        JUMPRT = 1'b0;
    logic [31:0] ImmExt = 32'd0;
    logic [31:0] ALUResult = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;
    logic [31:0] instret;

    int nChecks = 0;
    int nFail   = 0;
    int ackDelay = 0;
    int waitCnt  = 0;

    int          mPhase   = PH_FETCHING;
    logic [31:0] mPc      = RESET_PC;
    logic [31:0] mInstr   = NOP;
    logic [31:0] mInstret = 32'd0;
    logic        mFault   = 1'b0;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .PCsrc(PCsrc), .JUMPRT(JUMPRT),
        .ImmExt(ImmExt), .ALUResult(ALUResult),
        .pc(pc), .pc_plus4(pc_plus4),
        .fetch_fault(fetch_fault), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0], 16'h0000} ^ 32'h1234_0067 ^ {16'h0000, addr[31:16]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Responder answers a request after ackDelay cycles without ack
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (imem_req) begin
                if (waitCnt >= ackDelay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memWord(imem_addr);
                    waitCnt    = 0;
                end else begin
                    imem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                imem_ack = 1'b0;
                waitCnt  = 0;
            end
        end
    end

    // Reference model: one instruction is fetched, issued, then retired or faulted
    always @(posedge clk or posedge rst) begin
        logic [31:0] tgt;
        if (rst) begin
            mPhase   = PH_FETCHING;
            mPc      = RESET_PC;
            mInstr   = NOP;
            mInstret = 32'd0;
            mFault   = 1'b0;
        end else if (mPhase == PH_FETCHING) begin
            if (imem_ack) begin
                mInstr = memWord(mPc);
                mPhase = PH_ISSUING;
            end
        end else if (mPhase == PH_ISSUING && !stall) begin
            if (!PCsrc)      tgt = mPc + 32'd4;
            else if (JUMPRT) tgt = ALUResult - (ALUResult % 2);
            else             tgt = mPc + ImmExt;
            mInstr = NOP;
            if (tgt % 4 != 0) begin
                mFault = 1'b1;
                mPhase = PH_HALTED;
            end else begin
                mPc      = tgt;
                mInstret = mInstret + 32'd1;
                mPhase   = PH_FETCHING;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, (mPhase == PH_FETCHING) && !rst});
        checkOutput("imem_addr", imem_addr, mPc);
        checkOutput("instr", instr, mInstr);
        checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, mPhase == PH_ISSUING});
        checkOutput("pc", pc, mPc);
        checkOutput("pc_plus4", pc_plus4, mPc + 32'd4);
        checkOutput("fetch_fault", {31'd0, fetch_fault}, {31'd0, mFault});
        checkOutput("instret", instret, mInstret);
    end

    task automatic waitIssue(input string tag);
        bit got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (instr_valid) got = 1;
        end
        if (!got) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL %s: timed out waiting for issue, got instr_valid=0, want 1", tag);
        end
    endtask

    task automatic applyStimulus(input logic pcsrc, input logic jumprt, input logic [31:0] imm,
                                 input logic [31:0] alu);
        PCsrc     = pcsrc;
        JUMPRT    = jumprt;
        ImmExt    = imm;
        ALUResult = alu;
    endtask

    initial begin
        int cycles;
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rstPc", pc, 32'hBFC0_0000);
        checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
        checkOutput("rstInstr", instr, 32'h0000_0013);
        checkOutput("rstInstret", instret, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            waitIssue("seqIssue");
            checkOutput("seqPc", pc, 32'hBFC0_0000 + 32'(4 * k));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("seqInstret", instret, 32'd3);
        checkOutput("seqAddr", imem_addr, 32'hBFC0_000C);

        ackDelay = 2;
        waitIssue("delayIssue0C");
        cycles = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cycles++;
            if (instr_valid) break;
            checkOutput("delayReq", {31'd0, imem_req}, 32'd1);
            checkOutput("delayAddr", imem_addr, 32'hBFC0_0010);
            checkOutput("delayInstrHeld", instr, 32'h0000_0013);
        end
        checkOutput("delayCycles", 32'(cycles), 32'd4);
        checkOutput("delayInstr", instr, memWord(32'hBFC0_0010));

        ackDelay = 0;
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
        @(negedge clk);
        checkOutput("branchAddr", imem_addr, 32'hBFC0_0008);
        checkOutput("branchInstret", instret, 32'd5);

        applyStimulus(1'b1, 1'b1, 32'd0, 32'h0000_0105);
        waitIssue("jalrIssue");
        @(negedge clk);
        checkOutput("jalrPc", pc, 32'h0000_0104);

        stall = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        waitIssue("stallIssue");
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("stallValid", {31'd0, instr_valid}, 32'd1);
            checkOutput("stallPc", pc, 32'h0000_0104);
            checkOutput("stallInstr", instr, memWord(32'h0000_0104));
            checkOutput("stallInstret", instret, 32'd6);
        end
        stall = 1'b0;
        @(negedge clk);
        checkOutput("unstallPc", pc, 32'h0000_0108);
        checkOutput("unstallInstret", instret, 32'd7);
        #1 rst = 1'b1;
        #1;
        checkOutput("asyncRstReq", {31'd0, imem_req}, 32'd0);
        checkOutput("asyncRstPc", pc, 32'hBFC0_0000);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 32'h0000_0006, 32'd0);
        waitIssue("faultIssue");
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checkOutput("haltFault", {31'd0, fetch_fault}, 32'd1);
            checkOutput("haltReq", {31'd0, imem_req}, 32'd0);
            checkOutput("haltInstret", instret, 32'd0);
        end
        #1 rst = 1'b1;
        #1;
        checkOutput("faultCleared", {31'd0, fetch_fault}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
        waitIssue("selfBranch");
        @(negedge clk);
        checkOutput("selfBranchAddr", imem_addr, 32'hBFC0_0000);
        checkOutput("selfBranchInstret", instret, 32'd1);

        applyStimulus(1'b1, 1'b0, 32'h4040_0000, 32'd0);
        waitIssue("wrapBranch");
        @(negedge clk);
        checkOutput("wrapPc", pc, 32'h0000_0000);
        checkOutput("wrapPlus4", pc_plus4, 32'h0000_0004);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
